// File: rtl/regfile_dump_if.sv
// Byte stream carrying the register-file dump frame to a serial transmitter.
// The dump engine drives data/valid as master; the sink answers with ready.
interface regfile_dump_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump.sv
// Register file with two registered read ports, one write port and a dump engine
// that streams sync byte, every register byte-by-byte, then an XOR checksum.
module regfile_dump #(
  parameter int         XLEN      = 32,
  parameter int         NREGS     = 32,
  parameter int         ZERO_REG  = 1,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         LSB_FIRST = 1,
  localparam int        AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_b,
  input  logic            dump_req,
  output logic            dump_busy,
  output logic            dump_done,
  regfile_dump_if.master  tx
);

  localparam int BPR = XLEN / 8;
  localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPR - 1);
  localparam logic [AW-1:0] LAST_REG  = AW'(NREGS - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;

  state_t          state;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] shadow;
  logic [AW-1:0]   reg_idx;
  logic [BW-1:0]   byte_idx;
  logic [7:0]      csum;
  logic            wr_hit;
  logic [AW-1:0]   next_reg;
  logic [BW-1:0]   next_byte;

  function automatic logic in_range(input logic [AW-1:0] a);
    if (NREGS == (1 << AW)) return 1'b1;
    return ({1'b0, a} < (AW+1)'(NREGS));
  endfunction

  // Architectural view of a register: hard-wired zero and holes read as 0.
  function automatic logic [XLEN-1:0] word_at(input logic [AW-1:0] a);
    if (!in_range(a) || (ZERO_REG != 0 && a == '0)) return '0;
    return regs[a];
  endfunction

  function automatic logic [7:0] byte_of(input logic [XLEN-1:0] w, input logic [BW-1:0] k);
    int sel;
    sel = (LSB_FIRST != 0) ? int'(k) : (BPR - 1 - int'(k));
    return w[8*sel +: 8];
  endfunction

  assign wr_hit    = wr_en && in_range(wr_addr) && !(ZERO_REG != 0 && wr_addr == '0);
  assign next_reg  = reg_idx + 1'b1;
  assign next_byte = byte_idx + 1'b1;

  // NOTE: the storage array is reset here because the host may dump straight
  // after reset and must see a defined all-zero image, not power-up garbage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Write-first: a same-cycle write to the addressed register is forwarded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= (wr_hit && wr_addr == rd_addr_a) ? wr_data : word_at(rd_addr_a);
      rd_data_b <= (wr_hit && wr_addr == rd_addr_b) ? wr_data : word_at(rd_addr_b);
    end
  end

  // NOTE: every state bit uses <= so all reads in this block see pre-edge values,
  // which is what lets csum and tx_data be updated from each other safely.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      reg_idx     <= '0;
      byte_idx    <= '0;
      shadow      <= '0;
      csum        <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      dump_busy   <= 1'b0;
      dump_done   <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_req) begin
            state       <= SYNC;
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= SYNC_BYTE;
            dump_busy   <= 1'b1;
            reg_idx     <= '0;
            byte_idx    <= '0;
            csum        <= '0;
          end
        end
        SYNC: begin
          if (tx.tx_ready) begin
            state      <= DATA;
            shadow     <= word_at('0);
            tx.tx_data <= byte_of(word_at('0), '0);
          end
        end
        DATA: begin
          if (tx.tx_ready) begin
            csum <= csum ^ tx.tx_data;
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              if (reg_idx == LAST_REG) begin
                state      <= CSUM;
                tx.tx_data <= csum ^ tx.tx_data;
              end else begin
                // Latching the whole word keeps a concurrent write from tearing it.
                reg_idx    <= next_reg;
                shadow     <= word_at(next_reg);
                tx.tx_data <= byte_of(word_at(next_reg), '0);
              end
            end else begin
              byte_idx   <= next_byte;
              tx.tx_data <= byte_of(shadow, next_byte);
            end
          end
        end
        CSUM: begin
          if (tx.tx_ready) begin
            state       <= IDLE;
            tx.tx_valid <= 1'b0;
            dump_busy   <= 1'b0;
            dump_done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: reset, read/write/bypass, full dumps with and
// without backpressure, writes during a dump, ignored requests, abort, 16-bit variant.
module tb_regfile_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        wr_en;
  logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data, rd_data_a, rd_data_b;
  logic        dump_req, dump_busy, dump_done;
  regfile_dump_if m_if();

  logic        w2_en;
  logic [2:0]  w2_addr, r2_addr_a, r2_addr_b;
  logic [15:0] w2_data, r2_data_a, r2_data_b;
  logic        req2, busy2, done2;
  regfile_dump_if s_if();

  regfile_dump dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_done(dump_done), .tx(m_if.master)
  );

  regfile_dump #(.XLEN(16), .NREGS(8), .LSB_FIRST(0)) dut16 (
    .clk(clk), .rstn(rstn), .wr_en(w2_en), .wr_addr(w2_addr), .wr_data(w2_data),
    .rd_addr_a(r2_addr_a), .rd_data_a(r2_data_a), .rd_addr_b(r2_addr_b), .rd_data_b(r2_data_b),
    .dump_req(req2), .dump_busy(busy2), .dump_done(done2), .tx(s_if.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [7:0]  frame [$];
  logic [31:0] exp_regs [32];
  int          busy_cycles, done_cnt, stall_err, drop_err;
  bit          got_done;

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_dump();
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  // Sink for one frame. Triggers are keyed on the number of bytes accepted so far.
  task automatic run_frame(input bit rnd, input int req_at, input int wr_at, input int abort_at);
    bit         stalled = 1'b0;
    logic [7:0] held = '0;
    frame.delete();
    busy_cycles = 0; done_cnt = 0; stall_err = 0; drop_err = 0; got_done = 1'b0;
    for (int c = 0; c < 4000 && !got_done; c++) begin
      if (abort_at >= 0 && frame.size() == abort_at) begin
        rstn = 1'b0;
        #1;
        check("abort_tx_valid", m_if.tx_valid, 0);
        check("abort_busy", dump_busy, 0);
        m_if.tx_ready = 1'b0;
        return;
      end
      if (dump_done) begin done_cnt++; got_done = 1'b1; end
      if (dump_busy) busy_cycles++;
      if (dump_busy && !m_if.tx_valid) drop_err++;
      dump_req = (req_at >= 0 && frame.size() == req_at);
      if (wr_at >= 0 && frame.size() == wr_at) begin
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22222222;
      end else if (wr_at >= 0 && frame.size() == wr_at + 1) begin
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h33333333;
      end else begin
        wr_en = 1'b0;
      end
      if (m_if.tx_valid) begin
        if (stalled && m_if.tx_data !== held) stall_err++;
        m_if.tx_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
        if (m_if.tx_ready) begin
          frame.push_back(m_if.tx_data);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = m_if.tx_data;
        end
      end else begin
        m_if.tx_ready = 1'b0;
      end
      @(negedge clk);
    end
    dump_req = 1'b0; wr_en = 1'b0; m_if.tx_ready = 1'b0;
    check("frame_completed", got_done, 1);
  endtask

  task automatic check_frame(input string tag);
    logic [7:0]  exp [$];
    logic [7:0]  cs = '0;
    logic [31:0] w;
    exp.push_back(8'hA5);
    for (int r = 0; r < 32; r++) begin
      w = (r == 0) ? 32'h0 : exp_regs[r];
      for (int b = 0; b < 4; b++) begin
        exp.push_back(w[8*b +: 8]);
        cs ^= w[8*b +: 8];
      end
    end
    exp.push_back(cs);
    check({tag, "_len"}, frame.size(), exp.size());
    for (int i = 0; i < exp.size() && i < frame.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), frame[i], exp[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    logic [7:0] got2 [$];
    logic [7:0] exp2 [18];
    bit         done2_seen;

    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; dump_req = 1'b0; m_if.tx_ready = 1'b0;
    w2_en = 1'b0; w2_addr = '0; w2_data = '0; r2_addr_a = '0; r2_addr_b = '0;
    req2 = 1'b0; s_if.tx_ready = 1'b0;
    for (int r = 0; r < 32; r++) exp_regs[r] = '0;
    repeat (2) @(negedge clk);
    check("rst_rd_a", rd_data_a, 0);
    check("rst_rd_b", rd_data_b, 0);
    check("rst_tx_valid", m_if.tx_valid, 0);
    check("rst_tx_data", m_if.tx_data, 0);
    check("rst_busy", dump_busy, 0);
    check("rst_done", dump_done, 0);
    rstn = 1'b1;
    @(negedge clk);

    // T1: reset mid-run clears written registers
    write_reg(5'd3, 32'h55);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      @(negedge clk);
      check($sformatf("t1_rd_a%0d", i), rd_data_a, 0);
      check($sformatf("t1_rd_b%0d", 31 - i), rd_data_b, 0);
    end
    write_reg(5'd5, 32'hDEADBEEF);
    rd_addr_a = 5'd5;
    @(negedge clk);
    check("t1_rd_reg5", rd_data_a, 32'hDEADBEEF);

    // T2: zero register and write-first bypass
    write_reg(5'd0, 32'h1234);
    rd_addr_a = 5'd0;
    @(negedge clk);
    check("t2_reg0_zero", rd_data_a, 0);
    rd_addr_b = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFE0001;
    @(negedge clk);
    wr_en = 1'b0;
    check("t2_bypass_b", rd_data_b, 32'hCAFE0001);
    check("t2_reg0_still_zero", rd_data_a, 0);

    // T3: full dump with the sink always ready
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    write_reg(5'd1, 32'h04030201);
    exp_regs[1] = 32'h04030201;
    start_dump();
    run_frame(1'b0, -1, -1, -1);
    check_frame("t3");
    check("t3_sync", frame[0], 8'hA5);
    check("t3_reg1_b0", frame[5], 8'h01);
    check("t3_reg1_b3", frame[8], 8'h04);
    check("t3_csum", frame[129], 8'h04);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_busy_cycles", busy_cycles, 130);
    check("t3_valid_drops", drop_err, 0);
    @(negedge clk);
    check("t3_done_one_cycle", dump_done, 0);
    check("t3_idle_valid", m_if.tx_valid, 0);

    // T4: 30% ready duty, same frame, stable data while stalled
    start_dump();
    run_frame(1'b1, -1, -1, -1);
    check_frame("t4");
    check("t4_done_cnt", done_cnt, 1);
    check("t4_stall_changes", stall_err, 0);
    check("t4_valid_drops", drop_err, 0);

    // T5: writes to a latched and an unlatched register during the dump
    write_reg(5'd2, 32'h11111111);
    exp_regs[2] = 32'h11111111;
    start_dump();
    run_frame(1'b0, -1, 10, -1);
    exp_regs[31] = 32'h33333333;
    check_frame("t5");
    cs = '0;
    for (int i = 1; i < 129 && i < frame.size(); i++) cs ^= frame[i];
    check("t5_csum_vs_sent", frame[129], cs);
    exp_regs[2] = 32'h22222222;
    rd_addr_a = 5'd2; rd_addr_b = 5'd31;
    @(negedge clk);
    check("t5_reg2_after", rd_data_a, 32'h22222222);
    check("t5_reg31_after", rd_data_b, 32'h33333333);

    // T6: request while busy is dropped
    start_dump();
    run_frame(1'b0, 50, -1, -1);
    check_frame("t6_busy_req");
    check("t6_busy_req_done_cnt", done_cnt, 1);
    repeat (4) @(negedge clk);
    check("t6_no_second_frame", m_if.tx_valid, 0);

    // Request on the csum-accept edge is dropped; one cycle later it is taken
    start_dump();
    run_frame(1'b0, 129, -1, -1);
    check("t6_csum_edge_req_ignored", m_if.tx_valid, 0);
    start_dump();
    check("t6_next_cycle_req_taken", m_if.tx_valid, 1);
    run_frame(1'b0, -1, -1, -1);
    check_frame("t6_next_req");

    // Reset after 40 bytes aborts the frame without dump_done
    start_dump();
    run_frame(1'b0, -1, -1, 40);
    @(negedge clk);
    check("t6_abort_no_done", dump_done, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("t6_abort_idle_valid", m_if.tx_valid, 0);
    check("t6_abort_idle_done", dump_done, 0);
    for (int r = 0; r < 32; r++) exp_regs[r] = '0;
    start_dump();
    run_frame(1'b0, -1, -1, -1);
    check_frame("t6_after_reset");
    check("t6_after_reset_busy", busy_cycles, 130);
    check("t6_after_reset_done", done_cnt, 1);

    // T7: XLEN=16, NREGS=8, MSB byte first
    w2_en = 1'b1; w2_addr = 3'd1; w2_data = 16'h0102;
    @(negedge clk);
    w2_addr = 3'd7; w2_data = 16'hA0B0;
    @(negedge clk);
    w2_en = 1'b0;
    r2_addr_a = 3'd7; r2_addr_b = 3'd1;
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    check("t7_rd_a", r2_data_a, 16'hA0B0);
    check("t7_rd_b", r2_data_b, 16'h0102);
    exp2 = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA0, 8'hB0, 8'h13};
    done2_seen = 1'b0;
    for (int c = 0; c < 200 && !done2_seen; c++) begin
      if (done2) done2_seen = 1'b1;
      s_if.tx_ready = s_if.tx_valid;
      if (s_if.tx_valid) got2.push_back(s_if.tx_data);
      @(negedge clk);
    end
    s_if.tx_ready = 1'b0;
    check("t7_done", done2_seen, 1);
    check("t7_len", got2.size(), 18);
    for (int i = 0; i < 18 && i < got2.size(); i++)
      check($sformatf("t7_byte%0d", i), got2[i], exp2[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
